prog_fetch: RTL

//  Instruction fetch controller: the core-side initiator of the program-memory port.
//  - Owns the PC and drives progADDR/CoreStatus to progMEM.
//  - Captures the returned Instruction and presents it to decode.
//  - Handles decode back-pressure (stall), branch redirect, halt and PC wrap-around.

---
 rtl/prog_fetch_if.sv | 19 +
 rtl/prog_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/prog_fetch_if.sv
// ============================================================================
// Module  : prog_fetch_if
// Purpose : Program-memory port between the fetch unit and progMEM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_fetch_if #(
   parameter int TAM = 16
) ();
   logic [TAM-1:0] progADDR;
   logic [1:0]     CoreStatus;
   logic [15:0]    Instruction;

   modport master (output progADDR, output CoreStatus, input Instruction);
   modport slave  (input progADDR, input CoreStatus, output Instruction);
endinterface

`default_nettype wire

// File: rtl/prog_fetch.sv
// ============================================================================
// Module  : prog_fetch
// Purpose : Instruction fetch controller driving the program-memory port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_fetch #(
   parameter int TAM       = 16,
   parameter int Lmem      = 8,
   parameter int RESET_VEC = 0
) (
   input  wire logic            clk,
   input  wire logic            rst,
   prog_fetch_if.master         mem,
   input  wire logic            stall,
   input  wire logic            branch_en,
   input  wire logic [TAM-1:0]  branch_target,
   input  wire logic            halt_req,
   output logic      [15:0]     instr_out,
   output logic                 instr_valid,
   output logic      [TAM-1:0]  pc_out,
   output logic                 halted
);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [1:0] CS_RUN   = 2'b00;
   localparam logic [1:0] CS_STALL = 2'b01;
   localparam logic [1:0] CS_LOAD  = 2'b10;
   localparam logic [1:0] CS_HALT  = 2'b11;

   localparam logic [Lmem-1:0] PC_MAX = '1;
   localparam logic [Lmem-1:0] RST_PC = Lmem'(RESET_VEC);

   logic [1:0]      r_state;
   logic [1:0]      r_status;
   logic [Lmem-1:0] r_addr;
   logic [Lmem-1:0] r_pc;
   logic [15:0]     r_instr;
   logic            r_valid;
   logic            r_halted;
   logic [Lmem-1:0] w_cap_pc;

   // LOAD captures the word at progADDR itself; RUN captures the prefetched successor.
   assign w_cap_pc = (r_state == ST_LOAD) ? r_addr : r_pc + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_LOAD;
         r_status <= CS_LOAD;
         r_addr   <= RST_PC;
         r_pc     <= RST_PC;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else if (halt_req) begin
         r_state  <= ST_HALT;
         r_status <= CS_HALT;
         r_valid  <= 1'b0;
         r_halted <= 1'b1;
      end else if (branch_en) begin
         r_state  <= ST_LOAD;
         r_status <= CS_LOAD;
         r_addr   <= branch_target[Lmem-1:0];
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else if (r_state == ST_HALT) begin
         r_status <= CS_HALT;
      end else if ((r_state == ST_RUN) && stall) begin
         r_status <= CS_STALL;
      end else begin
         r_instr <= mem.Instruction;
         r_pc    <= w_cap_pc;
         r_valid <= 1'b1;
         // Reload from 0 at the top of memory so the prefetch never reaches 2^Lmem.
         if (w_cap_pc == PC_MAX) begin
            r_state  <= ST_LOAD;
            r_status <= CS_LOAD;
            r_addr   <= '0;
         end else begin
            r_state  <= ST_RUN;
            r_status <= CS_RUN;
            r_addr   <= w_cap_pc;
         end
      end
   end

   generate
      if (TAM > Lmem) begin : g_unused_target
         logic unused_target_bits;
         assign unused_target_bits = ^branch_target[TAM-1:Lmem];
      end
   endgenerate

   assign mem.progADDR   = TAM'(r_addr);
   assign mem.CoreStatus = r_status;
   assign instr_out      = r_instr;
   assign instr_valid    = r_valid;
   assign pc_out         = TAM'(r_pc);
   assign halted         = r_halted;

endmodule

`default_nettype wire
